dequeue_scheduler_v0_1: RTL and testbench
=========================================

Name: dequeue_scheduler_v0_1

Overview:
- Controller for the per-port PIFO plus packet-buffer queues that the enqueue agent fills.
- Round-robin arbitrates among the QUEUE_NUM output queues and pops the root entry of the granted queue's PIFO.
- Latches that entry's buffer address, then sequences buffer reads chunk by chunk until EOP, gated by the tx port's tready.
- Drives control and mux-select only; packet data muxing stays outside this block.

Parameters:
- QUEUE_NUM, 5: number of output queues (NF0-3, CPU).
- ADDR_WIDTH, 12: buffer address field width in the PIFO root entry.
- POP_TIMEOUT, 8: maximum cycles to wait for the PIFO pop response before aborting.
- CNT_WIDTH, 32: width of the dequeued-packet counter.

Ports:
- axis_aclk  in  1  clock
- axis_resetn  in  1  asynchronous active-low reset
- s_axis_pifo_empty  in  QUEUE_NUM  per-queue PIFO empty
- m_axis_ctl_pifo_out_en  out  QUEUE_NUM  one-hot pop pulse
- s_axis_pifo_out_valid  in  QUEUE_NUM  pop response valid, i.e. root valid bit
- s_axis_pifo_out_addr  in  QUEUE_NUM*ADDR_WIDTH  per-queue root buffer address; queue i occupies [i*ADDR_WIDTH +: ADDR_WIDTH]
- s_axis_pifo_out_ack  in  QUEUE_NUM  pop response strobe, asserted whether the root is valid or not
- m_axis_buffer_rd_addr  out  ADDR_WIDTH  latched start address of the packet being read
- m_axis_ctl_buffer_rd_en  out  QUEUE_NUM  per-queue buffer read/advance enable (combinational)
- s_axis_buffer_tvalid  in  QUEUE_NUM  buffer has a chunk available
- s_axis_buffer_tlast  in  QUEUE_NUM  current chunk is EOP
- s_axis_tx_tready  in  QUEUE_NUM  tx port accepts a chunk
- m_axis_grant  out  QUEUE_NUM  one-hot registered grant, used as the datapath mux select
- m_axis_busy  out  1  high in any state other than IDLE
- m_axis_pop_timeout  out  1  sticky error flag, cleared only by reset
- m_axis_deq_pkt_cnt  out  CNT_WIDTH  completed packets, wraps at 2^CNT_WIDTH

Behaviour:
- Reset (async, axis_resetn=0): state IDLE, rr_ptr=0, grant=0, rd_addr=0, counter=0, timeout flag=0.
  - All enables are 0 while in reset.
  - Reset asserted mid-packet abandons the packet with no further enables.
- Candidate mask: cand = ~s_axis_pifo_empty & s_axis_tx_tready.
- Arbitration: pick the first set bit of cand at an index >= rr_ptr, searching cyclically.
  - On grant g, rr_ptr <= (g+1) mod QUEUE_NUM. rr_ptr changes only on a grant.
- FSM states: IDLE, POP, WAIT_RSP, READ.
  - IDLE: if cand != 0, register grant = onehot(g) and go to POP. Otherwise stay in IDLE.
  - POP: m_axis_ctl_pifo_out_en = grant for exactly this one cycle. Clear the wait counter, go to WAIT_RSP.
  - WAIT_RSP: sample the granted queue's ack, valid and addr each cycle.
    - ack & valid: latch m_axis_buffer_rd_addr <= addr[g], go to READ.
    - ack & ~valid: the root was invalid. Go to IDLE, clear grant, no read, counter unchanged.
    - No ack for POP_TIMEOUT cycles: set m_axis_pop_timeout, go to IDLE, clear grant.
  - READ: m_axis_ctl_buffer_rd_en[g] = s_axis_buffer_tvalid[g] & s_axis_tx_tready[g]. All other bits are 0.
    - On rd_en[g] & tlast[g]: counter += 1, clear grant, go to IDLE.
    - If tx_tready or buffer_tvalid drops, the read stalls and the grant is held, with no timeout.
    - Empty or tready changes on other queues are ignored in this state.
- Latency: at most 2 cycles from cand rising in IDLE to the pop pulse (IDLE->POP registered).
  - First read is possible 1 cycle after ack.
  - Minimum dequeue gap between packets: 1 IDLE cycle.
- Only one packet is in flight at a time; one-hot invariants hold on grant, pop_en and rd_en.
- s_axis_pifo_empty changing between grant and POP does not alter the pop; a pop from an empty PIFO is handled by the ack & ~valid path.
- When QUEUE_NUM=1, arbitration degenerates to a fixed grant.

Decomposition:
- Shared package holds:
  - state encodings IDLE=0, POP=1, WAIT_RSP=2, READ=3, STATES_WIDTH=2;
  - the PIFO root field layout (valid bit 31, rank bits 30:12, addr bits 11:0);
  - QUEUE_NUM and port index constants (NF0..NF3, CPU=4).
- One sub-module: rr_arbiter. Inputs req[QUEUE_NUM] and ptr; outputs gnt one-hot and gnt_idx; purely combinational. Reused later by the multicast enqueue path.

Test Plan:
- Single packet: queue 2 non-empty, tready all 1, ack+valid with addr 0x0A5 two cycles after the pop, 3-chunk packet.
  - Expect pop_en=00100 for one cycle, rd_addr=0x0A5, three rd_en[2] pulses, cnt=1, grant=0 afterwards.
- Round-robin: queues 0, 1 and 4 continuously non-empty, 1-chunk packets.
  - Expect grant order 0,1,4,0,1,4 and rr_ptr wraps from 4 to 0.
- Backpressure: tx_tready[3] dropped for 5 cycles mid-packet.
  - Expect rd_en[3]=0 during those cycles, grant held at 01000, no chunk lost, completion on tlast.
- Invalid root: ack[1]=1 with valid[1]=0.
  - Expect return to IDLE with no rd_en pulse, cnt unchanged, queue 1 not retried before the rotation reaches it again.
- Timeout: no ack after the pop to queue 0.
  - Expect m_axis_pop_timeout=1 exactly POP_TIMEOUT=8 cycles after the WAIT_RSP entry, FSM in IDLE, the flag sticky.
- Async reset mid-READ (cnt=7): all outputs 0 immediately, without a clock edge; after release, rr_ptr=0 and the next grant goes to the lowest candidate.

Source files
------------

// File: rtl/dequeue_scheduler_v0_1_pkg.sv
// Shared definitions for the dequeue scheduler: FSM encoding, PIFO root layout
// and output-queue indices.
package dequeue_scheduler_v0_1_pkg;

    localparam int QUEUE_NUM = 5;

    localparam int PORT_NF0 = 0;
    localparam int PORT_NF1 = 1;
    localparam int PORT_NF2 = 2;
    localparam int PORT_NF3 = 3;
    localparam int PORT_CPU = 4;

    localparam int STATES_WIDTH = 2;

    typedef enum logic [STATES_WIDTH-1:0] {
        IDLE     = 2'd0,
        POP      = 2'd1,
        WAIT_RSP = 2'd2,
        READ     = 2'd3
    } state_t;

    // PIFO root entry as written by the enqueue agent
    localparam int ROOT_WIDTH     = 32;
    localparam int ROOT_VALID_BIT = 31;
    localparam int ROOT_RANK_MSB  = 30;
    localparam int ROOT_RANK_LSB  = 12;
    localparam int ROOT_ADDR_MSB  = 11;
    localparam int ROOT_ADDR_LSB  = 0;

    typedef struct packed {
        logic        valid;
        logic [18:0] rank;
        logic [11:0] addr;
    } pifo_root_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dequeue_scheduler_v0_1_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, searched
// cyclically. Also used by the multicast enqueue path.
module dequeue_scheduler_v0_1_rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(N)) begin
                sum = sum - (IDX_W + 1)'(N);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/dequeue_scheduler_v0_1.sv
// Dequeue scheduler: round-robin pick of an output queue, PIFO root pop,
// then chunk-by-chunk buffer read of the packet until EOP.
//
// state    | meaning
// IDLE     | waiting for a non-empty queue whose tx port is ready
// POP      | one-cycle pop pulse to the granted queue's PIFO
// WAIT_RSP | waiting for the pop ack, bounded by POP_TIMEOUT
// READ     | reading buffer chunks of the granted queue until EOP
module dequeue_scheduler_v0_1 #(
    parameter int QUEUE_NUM   = dequeue_scheduler_v0_1_pkg::QUEUE_NUM,
    parameter int ADDR_WIDTH  = 12,
    parameter int POP_TIMEOUT = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                            axis_aclk,
    input  logic                            axis_resetn,
    input  logic [QUEUE_NUM-1:0]            s_axis_pifo_empty,
    output logic [QUEUE_NUM-1:0]            m_axis_ctl_pifo_out_en,
    input  logic [QUEUE_NUM-1:0]            s_axis_pifo_out_valid,
    input  logic [QUEUE_NUM*ADDR_WIDTH-1:0] s_axis_pifo_out_addr,
    input  logic [QUEUE_NUM-1:0]            s_axis_pifo_out_ack,
    output logic [ADDR_WIDTH-1:0]           m_axis_buffer_rd_addr,
    output logic [QUEUE_NUM-1:0]            m_axis_ctl_buffer_rd_en,
    input  logic [QUEUE_NUM-1:0]            s_axis_buffer_tvalid,
    input  logic [QUEUE_NUM-1:0]            s_axis_buffer_tlast,
    input  logic [QUEUE_NUM-1:0]            s_axis_tx_tready,
    output logic [QUEUE_NUM-1:0]            m_axis_grant,
    output logic                            m_axis_busy,
    output logic                            m_axis_pop_timeout,
    output logic [CNT_WIDTH-1:0]            m_axis_deq_pkt_cnt
);
    import dequeue_scheduler_v0_1_pkg::*;

    localparam int IDX_W  = (QUEUE_NUM > 1) ? $clog2(QUEUE_NUM) : 1;
    localparam int WAIT_W = $clog2(POP_TIMEOUT + 1);

    state_t                 state;
    state_t                 state_next;
    logic [QUEUE_NUM-1:0]   cand;
    logic [QUEUE_NUM-1:0]   arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic [QUEUE_NUM-1:0]   grant;
    logic [IDX_W-1:0]       rr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [CNT_WIDTH-1:0]   pkt_cnt;
    logic                   timeout_flag;
    logic [WAIT_W-1:0]      wait_cnt;
    logic                   wait_expired;
    logic                   rsp_ack;
    logic                   rsp_valid;
    logic [ADDR_WIDTH-1:0]  rsp_addr;
    logic [QUEUE_NUM-1:0]   pop_en;
    logic [QUEUE_NUM-1:0]   rd_en;
    logic                   pkt_done;

    assign cand = ~s_axis_pifo_empty & s_axis_tx_tready;

    dequeue_scheduler_v0_1_rr_arbiter #(
        .N     (QUEUE_NUM),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (cand),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // grant is one-hot, so masking selects the granted queue's response
    assign rsp_ack      = |(s_axis_pifo_out_ack & grant);
    assign rsp_valid    = |(s_axis_pifo_out_valid & grant);
    assign wait_expired = (wait_cnt == WAIT_W'(POP_TIMEOUT - 1));
    assign pkt_done     = |(rd_en & s_axis_buffer_tlast);

    always_comb begin
        rsp_addr = '0;
        for (int q = 0; q < QUEUE_NUM; q++) begin
            if (grant[q]) begin
                rsp_addr = s_axis_pifo_out_addr[q*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop_en     = '0;
        rd_en      = '0;
        case (state)
            IDLE: begin
                if (|cand) begin
                    state_next = POP;
                end
            end
            POP: begin
                pop_en     = grant;
                state_next = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_ack) begin
                    state_next = rsp_valid ? READ : IDLE;
                end else if (wait_expired) begin
                    state_next = IDLE;
                end
            end
            READ: begin
                rd_en = grant & s_axis_buffer_tvalid & s_axis_tx_tready;
                if (|(grant & s_axis_buffer_tvalid & s_axis_tx_tready & s_axis_buffer_tlast)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            grant        <= '0;
            rr_ptr       <= '0;
            rd_addr      <= '0;
            pkt_cnt      <= '0;
            timeout_flag <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|cand) begin
                        grant  <= arb_gnt;
                        rr_ptr <= (arb_idx == IDX_W'(QUEUE_NUM - 1)) ? '0 : arb_idx + 1'b1;
                    end
                end
                POP: begin
                    wait_cnt <= '0;
                end
                WAIT_RSP: begin
                    if (rsp_ack) begin
                        if (rsp_valid) begin
                            rd_addr <= rsp_addr;
                        end else begin
                            grant <= '0;
                        end
                    end else if (wait_expired) begin
                        timeout_flag <= 1'b1;
                        grant        <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                READ: begin
                    if (pkt_done) begin
                        pkt_cnt <= pkt_cnt + 1'b1;
                        grant   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis_ctl_pifo_out_en  = pop_en;
    assign m_axis_ctl_buffer_rd_en = rd_en;
    assign m_axis_buffer_rd_addr   = rd_addr;
    assign m_axis_grant            = grant;
    assign m_axis_busy             = (state != IDLE);
    assign m_axis_pop_timeout      = timeout_flag;
    assign m_axis_deq_pkt_cnt      = pkt_cnt;

endmodule

// File: tb/tb_dequeue_scheduler_v0_1.sv
// Scoreboard bench for dequeue_scheduler_v0_1: the driver acts as PIFO, buffer
// and tx port, predicts each grant and read, and a monitor compares DUT pulses.
module tb_dequeue_scheduler_v0_1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  empty, pop_en, out_valid, ack, rd_en, tvalid, tlast, tready, grant;
    logic [59:0] out_addr;
    logic [11:0] rd_addr;
    logic        busy, tmo;
    logic [31:0] cnt;

    always #5 clk = ~clk;

    dequeue_scheduler_v0_1 dut (
        .axis_aclk               (clk),
        .axis_resetn             (rst_n),
        .s_axis_pifo_empty       (empty),
        .m_axis_ctl_pifo_out_en  (pop_en),
        .s_axis_pifo_out_valid   (out_valid),
        .s_axis_pifo_out_addr    (out_addr),
        .s_axis_pifo_out_ack     (ack),
        .m_axis_buffer_rd_addr   (rd_addr),
        .m_axis_ctl_buffer_rd_en (rd_en),
        .s_axis_buffer_tvalid    (tvalid),
        .s_axis_buffer_tlast     (tlast),
        .s_axis_tx_tready        (tready),
        .m_axis_grant            (grant),
        .m_axis_busy             (busy),
        .m_axis_pop_timeout      (tmo),
        .m_axis_deq_pkt_cnt      (cnt)
    );

    typedef struct { int q; int kind; logic tmo_before; } pop_exp_t;
    typedef struct { int q; bit last; logic [11:0] addr; logic [31:0] cnt; } rd_exp_t;

    pop_exp_t pop_q[$];
    rd_exp_t  rd_q[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          abort    = 0;
    int          model_ptr = 0;
    logic [31:0] model_cnt = 0;
    logic        model_tmo = 0;
    logic [4:0]  last_pop = '0;
    int          cyc = 0;
    int          tmo_chk = -100;
    logic        tmo_pre = 0;
    int          cnt_chk = -100;
    logic [31:0] cnt_exp = 0;
    int          rr_exp[6] = '{0, 1, 4, 0, 1, 4};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pop_en"}, pop_en, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tmo"}, tmo, 0);
        check({tag, "_cnt"}, cnt, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
    endtask

    // Monitor: compare every pop and read pulse against the scoreboard queues
    always @(negedge clk) begin
        pop_exp_t pe;
        rd_exp_t  re;
        cyc++;
        if (rst_n) begin
            check("onehot", {61'd0, $onehot0(grant), $onehot0(pop_en), $onehot0(rd_en)}, 64'd7);
            if (cnt_chk == cyc) check("pkt_cnt", cnt, cnt_exp);
            if (tmo_chk == cyc) check("tmo_before_deadline", tmo, tmo_pre);
            if (tmo_chk + 1 == cyc) begin
                check("tmo_set", tmo, 1);
                check("tmo_idle", busy, 0);
            end
            if (pop_en != 0) begin
                if (pop_q.size() == 0) fail_now("pop_unexpected", $sformatf("pop_en=0x%0h", pop_en));
                else begin
                    pe = pop_q.pop_front();
                    check("pop_en", pop_en, 5'b1 << pe.q);
                    check("pop_grant", grant, 5'b1 << pe.q);
                    if (pe.kind == 2) begin
                        tmo_chk = cyc + 8;
                        tmo_pre = pe.tmo_before;
                    end
                end
            end
            if (rd_en != 0) begin
                if (rd_q.size() == 0) fail_now("rd_unexpected", $sformatf("rd_en=0x%0h", rd_en));
                else begin
                    re = rd_q.pop_front();
                    check("rd_en", rd_en, 5'b1 << re.q);
                    check("rd_addr", rd_addr, re.addr);
                    check("rd_grant", grant, 5'b1 << re.q);
                    if (re.last) begin
                        cnt_chk = cyc + 1;
                        cnt_exp = re.cnt;
                    end
                end
            end
        end
    end

    // kind: 0 valid root, 1 invalid root, 2 no ack. Called in an IDLE cycle.
    task automatic run_pkt(input logic [4:0] emp, input logic [4:0] rdy, input int kind,
                           input logic [11:0] addr, input int len, input int dly,
                           input int stall_at, input int stall_len, input int rst_at, input bit rnd);
        logic [4:0]  cand;
        logic [63:0] r64;
        int          g;
        int          sent;
        int          rc;
        bit          seen;
        bit          tv;
        bit          tr;
        pop_exp_t    pe;
        rd_exp_t     re;
        if (abort) return;
        empty  = emp;
        tready = rdy;
        cand   = ~emp & rdy;
        if (cand == 0) begin
            repeat (3) step();
            return;
        end
        g = -1;
        for (int i = 0; i < 5; i++) begin
            if (g < 0 && cand[(model_ptr + i) % 5]) g = (model_ptr + i) % 5;
        end
        model_ptr     = (g + 1) % 5;
        pe.q          = g;
        pe.kind       = kind;
        pe.tmo_before = model_tmo;
        pop_q.push_back(pe);
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step();
            if (pop_en != 0) seen = 1;
        end
        if (!seen) begin
            fail_now("pop_wait", "no pop pulse within 4 cycles");
            abort = 1;
            return;
        end
        last_pop = pop_en;
        if (kind == 2) begin
            for (int i = 0; i < 9; i++) begin
                if (rnd) begin
                    ack       = 5'($urandom) & ~(5'b1 << g);
                    out_valid = 5'($urandom);
                end
                step();
            end
            ack       = '0;
            out_valid = '0;
            model_tmo = 1;
            return;
        end
        for (int i = 0; i < dly; i++) begin
            if (rnd) begin
                ack       = 5'($urandom) & ~(5'b1 << g);
                out_valid = 5'($urandom);
            end
            step();
        end
        ack          = (rnd ? (5'($urandom) & ~(5'b1 << g)) : 5'b0) | (5'b1 << g);
        out_valid[g] = (kind == 0);
        r64          = {$urandom(), $urandom()};
        out_addr     = r64[59:0];
        out_addr[g*12 +: 12] = addr;
        step();
        ack       = '0;
        out_valid = '0;
        if (kind == 1) return;
        sent = 0;
        rc   = 0;
        while (sent < len && !abort) begin
            tv = rnd ? ($urandom_range(3) != 0) : 1'b1;
            tr = rnd ? ($urandom_range(4) != 0) : 1'b1;
            if (rc >= stall_at && rc < stall_at + stall_len) begin
                tv = 1'b1;
                tr = 1'b0;
            end
            if (rnd) begin
                empty  = 5'($urandom);
                tready = 5'($urandom);
                tvalid = 5'($urandom);
                tlast  = 5'($urandom);
            end
            tvalid[g] = tv;
            tready[g] = tr;
            tlast[g]  = (sent == len - 1);
            if (sent == rst_at) begin
                tvalid[g] = 1'b1;
                tready[g] = 1'b1;
                tlast[g]  = 1'b0;
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("async_rst");
                model_ptr = 0;
                model_cnt = 0;
                model_tmo = 0;
                return;
            end
            if (tv && tr) begin
                re.q    = g;
                re.last = (sent == len - 1);
                re.addr = addr;
                re.cnt  = model_cnt + (re.last ? 32'd1 : 32'd0);
                rd_q.push_back(re);
                if (re.last) model_cnt = model_cnt + 1;
                sent++;
            end else if (rc >= stall_at && rc < stall_at + stall_len) begin
                #1;
                check("stall_rd_en", rd_en, 0);
                check("stall_grant", grant, 5'b1 << g);
            end
            step();
            rc++;
            if (rc > 200) begin
                fail_now("read_wait", "packet did not finish within 200 cycles");
                abort = 1;
            end
        end
        tvalid = '0;
        tlast  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int kind;
        rst_n     = 1'b0;
        empty     = '1;
        ack       = '0;
        out_valid = '0;
        out_addr  = '0;
        tvalid    = '0;
        tlast     = '0;
        tready    = '0;
        repeat (2) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // round robin over queues 0, 1 and 4
        for (int i = 0; i < 6; i++) begin
            run_pkt(5'b01100, 5'b11111, 0, 12'($urandom), 1, 1, -1, 0, -1, 0);
            check("rr_order", last_pop, 5'b1 << rr_exp[i]);
        end

        // single 3-chunk packet from queue 2
        run_pkt(5'b11011, 5'b11111, 0, 12'h0A5, 3, 2, -1, 0, -1, 0);
        check("single_pop", last_pop, 5'b00100);
        check("single_rd_addr", rd_addr, 12'h0A5);
        check("single_grant_clr", grant, 0);
        check("single_cnt", cnt, 32'd7);

        // async reset in the middle of the 8th packet
        run_pkt(5'b10111, 5'b11111, 0, 12'h3C3, 4, 1, -1, 0, 2, 0);
        empty  = '1;
        tvalid = '0;
        tlast  = '0;
        repeat (2) step();
        check_reset_outputs("rst_held");
        rst_n = 1'b1;
        run_pkt(5'b00101, 5'b11111, 0, 12'h111, 2, 1, -1, 0, -1, 0);
        check("post_rst_grant", last_pop, 5'b00010);

        // backpressure on queue 3
        run_pkt(5'b10111, 5'b11111, 0, 12'h7E1, 5, 1, 2, 5, -1, 0);
        check("bp_grant_clr", grant, 0);
        check("bp_cnt", cnt, 32'd2);

        // invalid root on queue 1, then rotation moves on to queue 2
        run_pkt(5'b11101, 5'b11111, 1, 12'h222, 1, 2, -1, 0, -1, 0);
        check("inv_busy", busy, 0);
        check("inv_grant", grant, 0);
        check("inv_cnt", cnt, 32'd2);
        run_pkt(5'b11001, 5'b11111, 0, 12'h333, 1, 1, -1, 0, -1, 0);
        check("inv_next", last_pop, 5'b00100);

        // pop timeout on queue 0
        run_pkt(5'b11110, 5'b11111, 2, 12'h000, 1, 1, -1, 0, -1, 0);
        check("tmo_flag", tmo, 1);
        check("tmo_busy", busy, 0);
        check("tmo_grant", grant, 0);

        // randomized traffic
        for (int i = 0; i < 60 && !abort; i++) begin
            r    = $urandom_range(99);
            kind = (r < 15) ? 1 : ((r < 20) ? 2 : 0);
            run_pkt(5'($urandom), ($urandom_range(1) != 0) ? 5'b11111 : 5'($urandom), kind,
                    12'($urandom), $urandom_range(4, 1), $urandom_range(4, 1), -1, 0, -1, 1);
        end

        empty  = '1;
        tvalid = '0;
        tlast  = '0;
        repeat (3) step();
        check("end_pop_q_empty", 64'(pop_q.size()), 0);
        check("end_rd_q_empty", 64'(rd_q.size()), 0);
        check("end_cnt", cnt, model_cnt);
        check("end_tmo_sticky", tmo, model_tmo);
        check("end_busy", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
